hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/cpu_pkg.sv | 32 +++
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/sb_match.sv | 52 +++++
 rtl/hazard_scoreboard.sv | 115 +++++++++++
 tb/tb_hazard_scoreboard.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the decode hazard scoreboard: in-flight slot record and
// the "no forwarding" select value.
package cpu_pkg;

    // Slot rd field is sized for the widest register file we build; narrower
    // REG_AW values are zero-extended on entry and on compare.
    localparam int unsigned SB_MAX_AW = 8;

    // fwd_sel value meaning "read the register file".
    localparam int unsigned FWD_NONE = 0;

    typedef struct packed {
        logic                 valid;
        logic [SB_MAX_AW-1:0] rd;
        logic                 wen;
        logic                 is_load;
    } sb_slot_st;

    localparam sb_slot_st SB_BUBBLE = '0;

    // Build a valid slot from a decode-stage instruction.
    function automatic sb_slot_st sb_make_slot(logic [SB_MAX_AW-1:0] rd, logic wen,
                                               logic is_load);
        sb_slot_st s;
        s.valid   = 1'b1;
        s.rd      = rd;
        s.wen     = wen;
        s.is_load = is_load;
        return s;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_if.sv
// Decode <-> scoreboard signal bundle. The decode stage is the master; the
// scoreboard is the slave and answers with stall/forwarding decisions.
interface hazard_scoreboard_if #(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned REG_AW     = 5
);
    localparam int unsigned FSW = $clog2(NUM_STAGES + 1);

    logic                                 issue_valid;
    logic [REG_AW-1:0]                    issue_rd;
    logic                                 issue_wen;
    logic                                 issue_is_load;
    logic [NUM_RPORTS-1:0][REG_AW-1:0]    rs_addr;
    logic [NUM_RPORTS-1:0]                rs_used;
    logic                                 flush;
    logic                                 ext_stall;

    logic                                 issue_fire;
    logic                                 stall;
    logic [NUM_RPORTS-1:0][FSW-1:0]       fwd_sel;
    logic [FSW-1:0]                       pend_cnt;
    logic [31:0]                          stall_cnt;

    modport master (
        output issue_valid, issue_rd, issue_wen, issue_is_load,
        output rs_addr, rs_used, flush, ext_stall,
        input  issue_fire, stall, fwd_sel, pend_cnt, stall_cnt
    );

    modport slave (
        input  issue_valid, issue_rd, issue_wen, issue_is_load,
        input  rs_addr, rs_used, flush, ext_stall,
        output issue_fire, stall, fwd_sel, pend_cnt, stall_cnt
    );

endinterface

// File: rtl/sb_match.sv
// One decode source port checked against every in-flight slot. The youngest
// (lowest index) matching slot wins; x0 never matches.
module sb_match
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned FSW        = 2
) (
    input  logic [REG_AW-1:0]           rs_addr_i,
    input  logic                        rs_used_i,
    input  sb_slot_st [NUM_STAGES-1:0]  slots_i,
    output logic                        match_o,
    output logic [FSW-1:0]              fwd_idx_o,
    output logic                        load_use_o
);

    logic [SB_MAX_AW-1:0]   addr_ext;
    logic [NUM_STAGES-1:0]  hit;
    logic [NUM_STAGES-1:0]  is_load_vec;
    logic                   unused_is_load;

    assign addr_ext = SB_MAX_AW'(rs_addr_i);

    // Per-slot raw hit: port live, non-zero address, slot writing that register.
    always_comb begin
        hit         = '0;
        is_load_vec = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            is_load_vec[k] = slots_i[k].is_load;
            hit[k] = rs_used_i && (rs_addr_i != '0) && slots_i[k].valid &&
                     slots_i[k].wen && (slots_i[k].rd == addr_ext);
        end
    end

    // Only slot 0's load flag matters; older loads have already returned data.
    assign unused_is_load = ^is_load_vec;

    // Priority resolve: walk oldest to youngest so the youngest hit is left.
    always_comb begin
        match_o    = |hit;
        fwd_idx_o  = FSW'(FWD_NONE);
        load_use_o = 1'b0;
        for (int k = NUM_STAGES - 1; k >= 0; k--) begin
            if (hit[k]) begin
                fwd_idx_o  = FSW'(k + 1);
                load_use_o = (k == 0) && is_load_vec[0];
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage data hazard scoreboard. Tracks destination registers of the
// instructions behind decode, produces per-port forwarding selects and a
// stall when a source cannot be satisfied (load-use, or any match when
// forwarding is disabled).
module hazard_scoreboard
    import cpu_pkg::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned NUM_RPORTS = 2,
    parameter int unsigned FWD_EN     = 1,
    parameter int unsigned REG_AW     = 5
) (
    input logic               clk,
    input logic               rst_n,
    hazard_scoreboard_if.slave bus
);

    localparam int unsigned FSW = $clog2(NUM_STAGES + 1);

    sb_slot_st [NUM_STAGES-1:0]      slots_q, slots_d;
    logic [31:0]                     stall_cnt_q, stall_cnt_d;

    logic [NUM_RPORTS-1:0]           port_match;
    logic [NUM_RPORTS-1:0]           port_load_use;
    logic [FSW-1:0]                  port_idx [NUM_RPORTS];

    logic                            hazard;
    logic                            issue_fire;
    logic                            stall;
    logic [NUM_RPORTS-1:0][FSW-1:0]  fwd_sel;
    logic [FSW-1:0]                  pend_cnt;

    for (genvar p = 0; p < NUM_RPORTS; p++) begin : g_port
        sb_match #(
            .NUM_STAGES (NUM_STAGES),
            .REG_AW     (REG_AW),
            .FSW        (FSW)
        ) u_match (
            .rs_addr_i  (bus.rs_addr[p]),
            .rs_used_i  (bus.rs_used[p]),
            .slots_i    (slots_q),
            .match_o    (port_match[p]),
            .fwd_idx_o  (port_idx[p]),
            .load_use_o (port_load_use[p])
        );
    end

    // Hazard and forwarding decision. A load-use port gets no forward select:
    // its data does not exist yet.
    always_comb begin
        hazard  = 1'b0;
        fwd_sel = '0;
        if (FWD_EN != 0) begin
            hazard = |port_load_use;
            for (int p = 0; p < NUM_RPORTS; p++) begin
                fwd_sel[p] = port_load_use[p] ? FSW'(FWD_NONE) : port_idx[p];
            end
        end else begin
            hazard = |port_match;
        end
    end

    // stall ignores ext_stall so the hazard stays visible during a freeze.
    assign stall      = bus.issue_valid & hazard & ~bus.flush;
    assign issue_fire = bus.issue_valid & ~hazard & ~bus.flush & ~bus.ext_stall;

    // Slot pipeline: freeze on ext_stall, otherwise shift and insert at slot 0.
    always_comb begin
        slots_d = slots_q;
        if (!bus.ext_stall) begin
            for (int k = NUM_STAGES - 1; k >= 1; k--) begin
                slots_d[k] = slots_q[k-1];
            end
            slots_d[0] = issue_fire ?
                sb_make_slot(SB_MAX_AW'(bus.issue_rd), bus.issue_wen, bus.issue_is_load) :
                SB_BUBBLE;
        end
    end

    // Hazard-stall cycle counter, saturating.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !bus.ext_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Count of in-flight register writers.
    always_comb begin
        pend_cnt = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (slots_q[k].valid && slots_q[k].wen) begin
                pend_cnt = pend_cnt + FSW'(1);
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            slots_q     <= slots_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.issue_fire = issue_fire;
    assign bus.stall      = stall;
    assign bus.fwd_sel    = fwd_sel;
    assign bus.pend_cnt   = pend_cnt;
    assign bus.stall_cnt  = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a forwarding instance (A) driven from
// a vector table plus corner sequences, and a no-forwarding instance (B).
module tb_hazard_scoreboard;

    logic clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    hazard_scoreboard_if #(.NUM_STAGES(3), .NUM_RPORTS(2), .REG_AW(5)) bus_a ();
    hazard_scoreboard_if #(.NUM_STAGES(3), .NUM_RPORTS(2), .REG_AW(5)) bus_b ();

    hazard_scoreboard #(
        .NUM_STAGES (3),
        .NUM_RPORTS (2),
        .FWD_EN     (1),
        .REG_AW     (5)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    hazard_scoreboard #(
        .NUM_STAGES (3),
        .NUM_RPORTS (2),
        .FWD_EN     (0),
        .REG_AW     (5)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [4:0] rd;
        logic       wen;
        logic       ld;
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] used;
        logic       flush;
        logic       e_stall;
        logic       e_fire;
        logic [1:0] e_fwd0;
        logic [1:0] e_fwd1;
        logic [1:0] e_pend;
        logic [31:0] e_scnt;
    } vec_t;

    vec_t vecs [13];

    function automatic vec_t mk(logic v, int rd, logic w, logic l, int r0, int r1,
                                logic [1:0] u, logic f, logic es, logic ef,
                                int f0, int f1, int pc, int sc);
        vec_t r;
        r.valid   = v;
        r.rd      = rd[4:0];
        r.wen     = w;
        r.ld      = l;
        r.rs0     = r0[4:0];
        r.rs1     = r1[4:0];
        r.used    = u;
        r.flush   = f;
        r.e_stall = es;
        r.e_fire  = ef;
        r.e_fwd0  = f0[1:0];
        r.e_fwd1  = f1[1:0];
        r.e_pend  = pc[1:0];
        r.e_scnt  = sc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive_a(input logic v, input int rd, input logic w, input logic l,
                           input int r0, input int r1, input logic [1:0] u,
                           input logic f, input logic xs);
        bus_a.issue_valid   = v;
        bus_a.issue_rd      = rd[4:0];
        bus_a.issue_wen     = w;
        bus_a.issue_is_load = l;
        bus_a.rs_addr[0]    = r0[4:0];
        bus_a.rs_addr[1]    = r1[4:0];
        bus_a.rs_used       = u;
        bus_a.flush         = f;
        bus_a.ext_stall     = xs;
    endtask

    task automatic drive_b(input logic v, input int rd, input logic w,
                           input int r0, input logic [1:0] u);
        bus_b.issue_valid   = v;
        bus_b.issue_rd      = rd[4:0];
        bus_b.issue_wen     = w;
        bus_b.issue_is_load = 1'b0;
        bus_b.rs_addr[0]    = r0[4:0];
        bus_b.rs_addr[1]    = 5'd0;
        bus_b.rs_used       = u;
        bus_b.flush         = 1'b0;
        bus_b.ext_stall     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // State tracked in comments as s0/s1/s2 (L = load).
        vecs[0]  = mk(0,  0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); // reset state
        vecs[1]  = mk(1,  5, 1, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 0, 0); // add x5
        vecs[2]  = mk(1,  9, 1, 0, 5, 0, 2'b01, 0, 0, 1, 1, 0, 1, 0); // x5 in s0 -> fwd 1
        vecs[3]  = mk(1,  0, 1, 0, 5, 9, 2'b11, 0, 0, 1, 2, 1, 2, 0); // x0 write tracked
        vecs[4]  = mk(1,  7, 1, 1, 0, 5, 2'b11, 0, 0, 1, 0, 3, 3, 0); // read x0: no match
        vecs[5]  = mk(1, 10, 1, 0, 0, 7, 2'b10, 0, 1, 0, 0, 0, 3, 0); // load-use on x7
        vecs[6]  = mk(1, 10, 1, 0, 0, 7, 2'b10, 0, 0, 1, 0, 2, 2, 1); // x7 now in s1
        vecs[7]  = mk(1, 11, 1, 0, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2, 1);
        vecs[8]  = mk(1,  4, 1, 1, 0, 0, 2'b00, 0, 0, 1, 0, 0, 2, 1); // lw x4
        vecs[9]  = mk(1, 12, 1, 0, 4, 0, 2'b01, 1, 0, 0, 0, 0, 3, 1); // hazard + flush
        vecs[10] = mk(0,  0, 0, 0, 4, 0, 2'b01, 0, 0, 0, 2, 0, 2, 1); // bubble: pend 3->2
        vecs[11] = mk(0,  0, 0, 0, 4, 0, 2'b01, 0, 0, 0, 3, 0, 1, 1);
        vecs[12] = mk(0,  0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1);

        drive_a(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        drive_b(0, 0, 0, 0, 2'b00);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Table-driven run on the forwarding instance.
        for (int i = 0; i < 13; i++) begin
            drive_a(vecs[i].valid, int'(vecs[i].rd), vecs[i].wen, vecs[i].ld,
                    int'(vecs[i].rs0), int'(vecs[i].rs1), vecs[i].used, vecs[i].flush, 0);
            @(negedge clk);
            chk($sformatf("row%0d stall", i), 32'(bus_a.stall), 32'(vecs[i].e_stall));
            chk($sformatf("row%0d fire", i), 32'(bus_a.issue_fire), 32'(vecs[i].e_fire));
            chk($sformatf("row%0d fwd0", i), 32'(bus_a.fwd_sel[0]), 32'(vecs[i].e_fwd0));
            chk($sformatf("row%0d fwd1", i), 32'(bus_a.fwd_sel[1]), 32'(vecs[i].e_fwd1));
            chk($sformatf("row%0d pend", i), 32'(bus_a.pend_cnt), 32'(vecs[i].e_pend));
            chk($sformatf("row%0d scnt", i), bus_a.stall_cnt, vecs[i].e_scnt);
            next_cycle();
        end

        // Freeze with x6 sitting in slot 1.
        drive_a(1, 6, 1, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        drive_a(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        next_cycle();
        for (int c = 0; c < 5; c++) begin
            drive_a(1, 13, 1, 0, 6, 0, 2'b01, 0, 1);
            @(negedge clk);
            chk($sformatf("freeze%0d fwd0", c), 32'(bus_a.fwd_sel[0]), 32'd2);
            chk($sformatf("freeze%0d fire", c), 32'(bus_a.issue_fire), 32'd0);
            chk($sformatf("freeze%0d stall", c), 32'(bus_a.stall), 32'd0);
            chk($sformatf("freeze%0d pend", c), 32'(bus_a.pend_cnt), 32'd1);
            chk($sformatf("freeze%0d scnt", c), bus_a.stall_cnt, 32'd1);
            next_cycle();
        end
        drive_a(1, 13, 1, 0, 6, 0, 2'b01, 0, 0);
        @(negedge clk);
        chk("thaw fire", 32'(bus_a.issue_fire), 32'd1);
        chk("thaw fwd0", 32'(bus_a.fwd_sel[0]), 32'd2);
        next_cycle();

        // Load-use overlapping a freeze: counter holds until the freeze drops.
        drive_a(1, 8, 1, 1, 0, 0, 2'b00, 0, 0);
        @(negedge clk);
        chk("lw8 pend", 32'(bus_a.pend_cnt), 32'd2);
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            drive_a(1, 14, 1, 0, 8, 0, 2'b01, 0, 1);
            @(negedge clk);
            chk($sformatf("xlu%0d stall", c), 32'(bus_a.stall), 32'd1);
            chk($sformatf("xlu%0d fire", c), 32'(bus_a.issue_fire), 32'd0);
            chk($sformatf("xlu%0d scnt", c), bus_a.stall_cnt, 32'd1);
            next_cycle();
        end
        drive_a(1, 14, 1, 0, 8, 0, 2'b01, 0, 0);
        @(negedge clk);
        chk("lu stall", 32'(bus_a.stall), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("lu done stall", 32'(bus_a.stall), 32'd0);
        chk("lu done fire", 32'(bus_a.issue_fire), 32'd1);
        chk("lu done fwd0", 32'(bus_a.fwd_sel[0]), 32'd2);
        chk("lu done scnt", bus_a.stall_cnt, 32'd2);
        next_cycle();

        // Reset pulse in the middle of a load-use stall.
        drive_a(1, 15, 1, 1, 0, 0, 2'b00, 0, 0);
        next_cycle();
        drive_a(1, 16, 1, 0, 0, 15, 2'b10, 0, 0);
        @(negedge clk);
        chk("pre-rst stall", 32'(bus_a.stall), 32'd1);
        chk("pre-rst pend", 32'(bus_a.pend_cnt), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("rst pend", 32'(bus_a.pend_cnt), 32'd0);
        chk("rst stall", 32'(bus_a.stall), 32'd0);
        chk("rst scnt", bus_a.stall_cnt, 32'd0);
        chk("rst fire", 32'(bus_a.issue_fire), 32'd1);
        #1;
        rst_n = 1'b1;
        next_cycle();
        drive_a(0, 0, 0, 0, 0, 0, 2'b00, 0, 0);
        @(negedge clk);
        chk("post-rst pend", 32'(bus_a.pend_cnt), 32'd1);
        chk("post-rst scnt", bus_a.stall_cnt, 32'd0);
        next_cycle();

        // No-forwarding instance: write x3 then read x3 stalls three cycles.
        drive_b(1, 3, 1, 0, 2'b00);
        @(negedge clk);
        chk("b wr3 fire", 32'(bus_b.issue_fire), 32'd1);
        next_cycle();
        for (int c = 0; c < 3; c++) begin
            drive_b(1, 20, 1, 3, 2'b01);
            @(negedge clk);
            chk($sformatf("b stall%0d", c), 32'(bus_b.stall), 32'd1);
            chk($sformatf("b fire%0d", c), 32'(bus_b.issue_fire), 32'd0);
            chk($sformatf("b fwd%0d", c), 32'(bus_b.fwd_sel[0]), 32'd0);
            next_cycle();
        end
        @(negedge clk);
        chk("b 4th stall", 32'(bus_b.stall), 32'd0);
        chk("b 4th fire", 32'(bus_b.issue_fire), 32'd1);
        chk("b scnt", bus_b.stall_cnt, 32'd3);
        next_cycle();
        drive_b(0, 0, 0, 0, 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
